wave_cmd_decoder: RTL

- Upstream control stage between the SPI byte receiver and the var_clk/memory waveform engine.
- Synchronises the receiver's byte strobe into the system clock domain and decodes one- and two-byte commands into registered waveform configuration.
- Generates a clean, fixed-width, clock-synchronous mem_rst pulse on waveform change, so the engine is never clocked by a data-derived strobe.

---
 rtl/wave_cmd_decoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wave_cmd_decoder.sv
// Command decoder between the SPI byte receiver and the waveform engine: synchronises the
// byte strobe, decodes one/two-byte commands and emits a clean fixed-width mem_rst pulse.
module wave_cmd_decoder #(
   parameter int         RST_PULSE_CYCLES = 2,
   parameter int         TIMEOUT_CYCLES   = 1200000,
   parameter logic [7:0] AMP_DEFAULT      = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cmd_byte,
   input  logic       cmd_strobe,
   output logic [3:0] wave_sel,
   output logic [7:0] amplitude,
   output logic [9:0] offset,
   output logic       mem_rst,
   output logic       cfg_update,
   output logic       err
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int PW = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT_AMP, WAIT_OFF, PULSE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      strbSync_q;
   logic            capValid_q;
   logic [7:0]      capByte_q;
   logic [3:0]      waveSel_q, waveSel_d;
   logic [7:0]      amp_q, amp_d;
   logic [9:0]      offset_q, offset_d;
   logic [1:0]      offHi_q, offHi_d;
   logic            memRst_q;
   logic            cfgUpd_q, cfgUpd_d;
   logic            err_q, err_d;
   logic            bufValid_q, bufValid_d;
   logic [7:0]      bufByte_q, bufByte_d;
   logic [TW-1:0]   tmoCnt_q, tmoCnt_d;
   logic [PW-1:0]   pulseCnt_q, pulseCnt_d;
   logic            edgeDet;
   logic            haveByte;
   logic [7:0]      curByte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strbSync_q <= '0;
         capValid_q <= 1'b0;
         capByte_q  <= '0;
         state_q    <= IDLE;
         waveSel_q  <= '0;
         amp_q      <= AMP_DEFAULT;
         offset_q   <= '0;
         offHi_q    <= '0;
         memRst_q   <= 1'b0;
         cfgUpd_q   <= 1'b0;
         err_q      <= 1'b0;
         bufValid_q <= 1'b0;
         bufByte_q  <= '0;
         tmoCnt_q   <= '0;
         pulseCnt_q <= '0;
      end else begin
         strbSync_q <= {strbSync_q[1:0], cmd_strobe};
         capValid_q <= edgeDet;
         if (edgeDet) begin
            capByte_q <= cmd_byte;
         end
         state_q    <= state_d;
         waveSel_q  <= waveSel_d;
         amp_q      <= amp_d;
         offset_q   <= offset_d;
         offHi_q    <= offHi_d;
         memRst_q   <= (state_d == PULSE);
         cfgUpd_q   <= cfgUpd_d;
         err_q      <= err_d;
         bufValid_q <= bufValid_d;
         bufByte_q  <= bufByte_d;
         tmoCnt_q   <= tmoCnt_d;
         pulseCnt_q <= pulseCnt_d;
      end
   end

   // A held byte always drains before a freshly captured one, which then takes its place.
   always_comb begin
      edgeDet    = strbSync_q[1] & ~strbSync_q[2];
      haveByte   = bufValid_q | capValid_q;
      curByte    = bufValid_q ? bufByte_q : capByte_q;
      state_d    = state_q;
      waveSel_d  = waveSel_q;
      amp_d      = amp_q;
      offset_d   = offset_q;
      offHi_d    = offHi_q;
      err_d      = err_q;
      cfgUpd_d   = 1'b0;
      bufValid_d = bufValid_q;
      bufByte_d  = bufByte_q;
      tmoCnt_d   = '0;
      pulseCnt_d = '0;

      if (state_q != PULSE && bufValid_q) begin
         bufValid_d = capValid_q;
         bufByte_d  = capByte_q;
      end

      case (state_q)
         IDLE: begin
            if (haveByte) begin
               case (curByte[7:4])
                  4'h0: state_d = IDLE;
                  4'h1: begin
                     waveSel_d = curByte[3:0];
                     cfgUpd_d  = 1'b1;
                     state_d   = PULSE;
                  end
                  4'h2: state_d = WAIT_AMP;
                  4'h3: begin
                     offHi_d = curByte[1:0];
                     state_d = WAIT_OFF;
                  end
                  4'h4: begin
                     waveSel_d = '0;
                     amp_d     = AMP_DEFAULT;
                     offset_d  = '0;
                     err_d     = 1'b0;
                     cfgUpd_d  = 1'b1;
                     state_d   = PULSE;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         WAIT_AMP, WAIT_OFF: begin
            if (haveByte) begin
               if (state_q == WAIT_AMP) begin
                  amp_d = curByte;
               end else begin
                  offset_d = {offHi_q, curByte};
               end
               cfgUpd_d = 1'b1;
               state_d  = IDLE;
            end else if (tmoCnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmoCnt_d = tmoCnt_q + 1'b1;
            end
         end
         PULSE: begin
            if (capValid_q) begin
               if (bufValid_q) begin
                  err_d = 1'b1;
               end else begin
                  bufValid_d = 1'b1;
                  bufByte_d  = capByte_q;
               end
            end
            if (pulseCnt_q == PULSE_LAST) begin
               state_d = IDLE;
            end else begin
               pulseCnt_d = pulseCnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wave_sel   = waveSel_q;
   assign amplitude  = amp_q;
   assign offset     = offset_q;
   assign mem_rst    = memRst_q;
   assign cfg_update = cfgUpd_q;
   assign err        = err_q;

endmodule
